ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Access controller for the dual-port register-file RAM (synchronous write on port X, asynchronous reads on X and Y). It sits between the CPU datapath, a single-word debug requester and the RAM. It zero-clears the whole RAM after reset or on command, and shares the single write/X port between the two requesters. CPU accesses have priority, and a starvation guard forces the debug access through.

## Interface
Parameters:
- ADDR_SIZE, 5, RAM address width; depth = 2^ADDR_SIZE
- DATA_SIZE, 8, RAM data width
- STARVE_LIM, 4, consecutive denied debug-request cycles before a forced grant (≥1)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- CPU_WE  in  1  CPU write enable
- CPU_ADRX, CPU_ADRY  in  ADDR_SIZE  CPU X/Y addresses
- CPU_DIN  in  DATA_SIZE  CPU write data
- CPU_STALL  out  1  CPU must hold its current access; RAM not driven by CPU this cycle
- CLR_START  in  1  request full RAM clear
- BUSY  out  1  clear in progress
- DBG_REQ  in  1  debug access request; hold with DBG_WR/ADR/DIN stable until DBG_ACK
- DBG_WR  in  1  1 = write, 0 = read
- DBG_ADR  in  ADDR_SIZE  debug address
- DBG_DIN  in  DATA_SIZE  debug write data
- DBG_ACK  out  1  one-cycle completion pulse (registered)
- DBG_DOUT  out  DATA_SIZE  registered data at DBG_ADR, valid from DBG_ACK until next ACK
- RAM_WE  out  1, RAM_ADRX / RAM_ADRY  out  ADDR_SIZE, RAM_DIN  out  DATA_SIZE  RAM drive
- RAM_DX_OUT  in  DATA_SIZE  RAM port X async read data (RAM_DY_OUT goes to the CPU directly)

## Operation
- States: CLEAR, IDLE, DBG. RST → CLEAR with clr_cnt=0, starve_cnt=0, DBG_ACK=0, DBG_DOUT=0.
- CLEAR:
  - Drives RAM_WE=1, RAM_ADRX=clr_cnt, RAM_DIN=0, RAM_ADRY=CPU_ADRY.
  - CPU_STALL=1, BUSY=1.
  - clr_cnt (ADDR_SIZE bits) increments each cycle. When clr_cnt = all-ones, next state is IDLE.
  - CLR_START is ignored. DBG_REQ waits.
- IDLE:
  - RAM_* = CPU_* (passthrough), CPU_STALL=0, BUSY=0.
  - Priority: CLR_START → CLEAR (clr_cnt=0). Otherwise, if DBG_REQ and (CPU_WE=0 or starve_cnt=STARVE_LIM) and DBG_ACK=0 → DBG. Otherwise stay.
  - The CPU write in the transition cycle is always performed.
- starve_cnt:
  - Increments in IDLE cycles with DBG_REQ=1, DBG_ACK=0 and no grant.
  - Saturates at STARVE_LIM.
  - Clears on grant, CLEAR entry or RST.
- DBG (exactly one cycle):
  - Drives CPU_STALL=1, RAM_ADRX=DBG_ADR, RAM_WE=DBG_WR, RAM_DIN=DBG_DIN, RAM_ADRY=CPU_ADRY.
  - CPU write is suppressed; the CPU holds it and retries.
  - At the closing edge: DBG_DOUT ← RAM_DX_OUT (for a write, this is the pre-write content), DBG_ACK ← 1, next state is IDLE.
- DBG_ACK is high for one cycle. DBG_REQ is ignored in the ACK cycle, so there are no back-to-back grants. The requester drops DBG_REQ in the ACK cycle or issues a new request.

## Timing
- Reset: the first edge with RST=1 enters CLEAR. Clear takes 2^ADDR_SIZE cycles (32 by default). The first IDLE cycle follows the write to address 2^ADDR_SIZE−1.
- Outputs during/after reset: CPU_STALL=1, BUSY=1, DBG_ACK=0, DBG_DOUT=0.
- Debug latency: DBG_REQ sampled high at edge t with CPU_WE=0 in IDLE → DBG in cycle t+1 → DBG_ACK high in t+2.
- Forced grant: with CPU_WE held at 1, the grant occurs at the edge after STARVE_LIM denied cycles. The CPU is stalled for exactly one cycle.
- CLR_START and DBG_REQ in the same IDLE cycle: clear wins, and debug is served after clear completes.
- RST during CLEAR restarts at address 0. RST during DBG: no ACK, no write is suppressed beyond that cycle, and the pending request is served after clear.
- CLR_START while in DBG: ignored. The requester re-asserts it.

## Test plan
- RST for one cycle → 32 cycles of RAM_WE=1, RAM_ADRX 0..31, RAM_DIN=0, CPU_STALL=BUSY=1. Cycle 33: CPU_STALL=0, BUSY=0.
- IDLE, CPU_WE=0, debug write ADR=5 DIN=0xA5 → one DBG cycle with RAM_WE=1, RAM_ADRX=5; DBG_ACK pulses once. A following debug read ADR=5 → DBG_DOUT=0xA5 at ACK.
- CPU write ADR=3 DIN=0x3C, CPU_ADRY=3 → RAM_WE=1, RAM_ADRX=3 passthrough; next cycle RAM_DY_OUT=0x3C; CPU_STALL=0 throughout.
- CPU_WE=1 every cycle with DBG_REQ held (read ADR=3) → grant after 4 denied cycles, CPU_STALL=1 for one cycle, RAM_WE=0, DBG_DOUT=0x3C; no second grant in the ACK cycle.
- CLR_START and DBG_REQ (read ADR=5) in the same cycle, with addr 5 = 0xA5 → 32-cycle clear first, then DBG; DBG_DOUT=0x00.
- RST asserted when clr_cnt=10 → clear restarts at address 0 and runs a full 32 cycles; no DBG_ACK is issued meanwhile.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: bundles the CPU, clear, debug and RAM-side signals of the RAM access controller.
//   cpu_*      : CPU datapath access (we, X/Y address, write data) and the returned stall
//   clr_start  : full-RAM clear request; busy reports a clear in progress
//   dbg_*      : single-word debug request/response (req, wr, adr, din -> ack, dout)
//   ram_*      : drive towards the RAM (we, X/Y address, write data) and its async X read data
//   slave      : controller view; master: view of the surrounding datapath/requester/RAM
interface ram_access_ctrl_if #(
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 8
);
   logic                 cpu_we;
   logic [ADDR_SIZE-1:0] cpu_adrx;
   logic [ADDR_SIZE-1:0] cpu_adry;
   logic [DATA_SIZE-1:0] cpu_din;
   logic                 cpu_stall;
   logic                 clr_start;
   logic                 busy;
   logic                 dbg_req;
   logic                 dbg_wr;
   logic [ADDR_SIZE-1:0] dbg_adr;
   logic [DATA_SIZE-1:0] dbg_din;
   logic                 dbg_ack;
   logic [DATA_SIZE-1:0] dbg_dout;
   logic                 ram_we;
   logic [ADDR_SIZE-1:0] ram_adrx;
   logic [ADDR_SIZE-1:0] ram_adry;
   logic [DATA_SIZE-1:0] ram_din;
   logic [DATA_SIZE-1:0] ram_dx_out;
   modport slave (
      input  cpu_we, cpu_adrx, cpu_adry, cpu_din, clr_start,
      input  dbg_req, dbg_wr, dbg_adr, dbg_din, ram_dx_out,
      output cpu_stall, busy, dbg_ack, dbg_dout,
      output ram_we, ram_adrx, ram_adry, ram_din
   );
   modport master (
      output cpu_we, cpu_adrx, cpu_adry, cpu_din, clr_start,
      output dbg_req, dbg_wr, dbg_adr, dbg_din, ram_dx_out,
      input  cpu_stall, busy, dbg_ack, dbg_dout,
      input  ram_we, ram_adrx, ram_adry, ram_din
   );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: clears the register-file RAM after reset or on request and shares its write/X port
// between the CPU (priority) and a single-word debug requester with a starvation guard.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, restarts the clear from address 0
//   b   : ram_access_ctrl_if.slave (CPU, clear, debug and RAM signals)
module ram_access_ctrl #(
   parameter int ADDR_SIZE  = 5,
   parameter int DATA_SIZE  = 8,
   parameter int STARVE_LIM = 4
) (
   input logic clk,
   input logic rst,
   ram_access_ctrl_if.slave b
);
   localparam int SW = $clog2(STARVE_LIM + 1);
   typedef enum logic [1:0] {CLEAR, IDLE, DBG} state_t;
   state_t state, state_nx;
   logic [ADDR_SIZE-1:0] clr_cnt;
   logic [SW-1:0] starve_cnt;
   logic starved, grant;
   assign starved = starve_cnt == SW'(STARVE_LIM);
   // ack cycle blocks a new grant so debug accesses are never back to back
   assign grant = state == IDLE && !b.clr_start && b.dbg_req && !b.dbg_ack && (!b.cpu_we || starved);
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         starve_cnt <= '0;
         b.dbg_ack  <= 1'b0;
         b.dbg_dout <= '0;
      end else begin
         state      <= state_nx;
         // held at zero outside CLEAR so every clear entry starts at address 0
         clr_cnt    <= state == CLEAR ? clr_cnt + 1'b1 : '0;
         starve_cnt <= (state != IDLE || b.clr_start || grant) ? '0 :
                       (b.dbg_req && !b.dbg_ack && !starved) ? starve_cnt + 1'b1 : starve_cnt;
         b.dbg_ack  <= state == DBG;
         if (state == DBG)
            b.dbg_dout <= b.ram_dx_out;
      end
   end
   always_comb begin
      state_nx    = IDLE;
      state_nx    = state == CLEAR ? (&clr_cnt ? IDLE : CLEAR) :
                    state == IDLE  ? (b.clr_start ? CLEAR : grant ? DBG : IDLE) : IDLE;
      b.ram_adry  = b.cpu_adry;
      b.ram_we    = state == CLEAR ? 1'b1 : state == DBG ? b.dbg_wr : b.cpu_we;
      b.ram_adrx  = state == CLEAR ? clr_cnt : state == DBG ? b.dbg_adr : b.cpu_adrx;
      b.ram_din   = state == CLEAR ? {DATA_SIZE{1'b0}} : state == DBG ? b.dbg_din : b.cpu_din;
      b.cpu_stall = state != IDLE;
      b.busy      = state == CLEAR;
   end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed self-checking bench for ram_access_ctrl with a RAM model and a debug-read scoreboard.
module tb_ram_access_ctrl;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   logic [7:0] mem [32];
   logic [7:0] gold [32];
   logic [7:0] exp_q [$];
   logic [7:0] dy;
   ram_access_ctrl_if #(.ADDR_SIZE(5), .DATA_SIZE(8)) b ();
   ram_access_ctrl #(.ADDR_SIZE(5), .DATA_SIZE(8), .STARVE_LIM(4)) dut (.clk(clk), .rst(rst), .b(b));
   always #5 clk = ~clk;
   always @(posedge clk) if (b.ram_we === 1'b1) mem[b.ram_adrx] <= b.ram_din;
   assign b.ram_dx_out = mem[b.ram_adrx];
   assign dy = mem[b.ram_adry];
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (b.dbg_ack === 1'b1) begin
         if (exp_q.size() == 0) check("ack_unexpected", b.dbg_ack, 1'b0);
         else check("dbg_dout", b.dbg_dout, exp_q.pop_front());
      end
   end
   task automatic clear_run();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         check("clear", {b.ram_we, b.ram_adrx, b.ram_din, b.cpu_stall, b.busy, b.dbg_ack},
               {1'b1, 5'(i), 8'h00, 1'b1, 1'b1, 1'b0});
         cyc();
      end
      @(negedge clk);
      check("clear_done", {b.cpu_stall, b.busy}, 2'b00);
      for (int i = 0; i < 32; i++) gold[i] = 8'h00;
   endtask
   task automatic dbg_txn(input logic wr, input logic [4:0] a, input logic [7:0] d);
      b.dbg_req = 1'b1; b.dbg_wr = wr; b.dbg_adr = a; b.dbg_din = d; b.cpu_we = 1'b0;
      exp_q.push_back(gold[a]);
      if (wr) gold[a] = d;
      @(negedge clk);
      check("dbg_req_idle", b.cpu_stall, 1'b0);
      cyc();
      @(negedge clk);
      check("dbg_drive", {b.cpu_stall, b.ram_we, b.ram_adrx, b.ram_din}, {1'b1, wr, a, d});
      cyc();
      b.dbg_req = 1'b0;
      @(negedge clk);
      check("dbg_ack", b.dbg_ack, 1'b1);
      cyc();
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
      b.cpu_we = 0; b.cpu_adrx = 0; b.cpu_adry = 0; b.cpu_din = 0; b.clr_start = 0;
      b.dbg_req = 0; b.dbg_wr = 0; b.dbg_adr = 0; b.dbg_din = 0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      check("rst_ack_dout", {b.dbg_ack, b.dbg_dout}, 9'h000);
      clear_run();
      cyc();
      dbg_txn(1'b1, 5'd5, 8'hA5);
      dbg_txn(1'b0, 5'd5, 8'h00);
      b.cpu_we = 1; b.cpu_adrx = 3; b.cpu_din = 8'h3C; b.cpu_adry = 3;
      gold[3] = 8'h3C;
      @(negedge clk);
      check("cpu_pass", {b.cpu_stall, b.ram_we, b.ram_adrx, b.ram_din}, {1'b0, 1'b1, 5'd3, 8'h3C});
      cyc();
      b.cpu_we = 0;
      @(negedge clk);
      check("cpu_dy", {b.cpu_stall, dy}, {1'b0, gold[3]});
      cyc();
      b.cpu_we = 1; b.cpu_adrx = 7; b.cpu_din = 8'h77;
      b.dbg_req = 1; b.dbg_wr = 0; b.dbg_adr = 3;
      exp_q.push_back(gold[3]);
      gold[7] = 8'h77;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("starve_wait", {b.cpu_stall, b.ram_we, b.ram_adrx}, {1'b0, 1'b1, 5'd7});
         cyc();
      end
      @(negedge clk);
      check("forced_dbg", {b.cpu_stall, b.ram_we, b.ram_adrx}, {1'b1, 1'b0, 5'd3});
      cyc();
      b.cpu_we = 0;
      @(negedge clk);
      check("forced_ack", {b.dbg_ack, b.cpu_stall}, 2'b10);
      cyc();
      b.dbg_req = 0;
      @(negedge clk);
      check("no_regrant", {b.dbg_ack, b.cpu_stall}, 2'b00);
      cyc();
      b.clr_start = 1; b.dbg_req = 1; b.dbg_wr = 0; b.dbg_adr = 5;
      exp_q.push_back(8'h00);
      @(negedge clk);
      check("clr_dbg_idle", b.cpu_stall, 1'b0);
      cyc();
      b.clr_start = 0;
      clear_run();
      cyc();
      @(negedge clk);
      check("post_clr_dbg", {b.cpu_stall, b.ram_we, b.ram_adrx}, {1'b1, 1'b0, 5'd5});
      cyc();
      b.dbg_req = 0;
      @(negedge clk);
      check("post_clr_ack", b.dbg_ack, 1'b1);
      cyc();
      b.clr_start = 1; b.dbg_req = 1; b.dbg_wr = 1; b.dbg_adr = 9; b.dbg_din = 8'h99;
      exp_q.push_back(8'h00);
      cyc();
      b.clr_start = 0;
      for (int i = 0; i < 11; i++) begin
         rst = (i == 10);
         @(negedge clk);
         check("clr_pre_rst", {b.ram_adrx, b.busy, b.dbg_ack}, {5'(i), 1'b1, 1'b0});
         cyc();
      end
      rst = 0;
      clear_run();
      gold[9] = 8'h99;
      cyc();
      @(negedge clk);
      check("rst_pend_dbg", {b.cpu_stall, b.ram_we, b.ram_adrx, b.ram_din}, {1'b1, 1'b1, 5'd9, 8'h99});
      cyc();
      b.dbg_req = 0;
      @(negedge clk);
      check("rst_pend_ack", b.dbg_ack, 1'b1);
      cyc();
      dbg_txn(1'b0, 5'd9, 8'h00);
      dbg_txn(1'b0, 5'd7, 8'h00);
      @(negedge clk);
      check("sb_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
